// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch stage of the RV32I subset core. Owns the fetch PC, issues word
// requests to instruction memory (request/grant, in-order responses with no
// backpressure), buffers returned words in a DEPTH-entry FIFO and presents the
// head instruction to decode with a valid/ready handshake, pre-split into
// OP/Funct3/Funct7. A taken BEQ flushes the buffer, marks every in-flight
// word as stale and redirects the fetch PC.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   imem_req / imem_addr       fetch request and word-aligned byte address
//   imem_gnt                   memory accepts the request this cycle
//   imem_rvalid / imem_rdata   in-order response word
//   BranchTaken / BranchTarget redirect strobe and target ([1:0] ignored)
//   InstrValid / InstrReady    decode handshake for the head instruction
//   Instr, PC, PCPlus4         head instruction, its address, address + 4
//   OP, Funct3, Funct7         Instr[6:0], Instr[14:12], Instr[31:25]
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int unsigned          XLEN     = 32,
  parameter logic [XLEN-1:0]      RESET_PC = 32'h0000_0000,
  parameter int unsigned          DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            BranchTaken,
  input  logic [XLEN-1:0] BranchTarget,
  output logic            InstrValid,
  input  logic            InstrReady,
  output logic [31:0]     Instr,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PCPlus4,
  output logic [6:0]      OP,
  output logic [2:0]      Funct3,
  output logic [6:0]      Funct7
);

  // Counter widths: occupancy/in-flight/drop counts range over 0..DEPTH.
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned SW = CW + 1;

  localparam logic [31:0]     NOP_INSTR  = 32'h0000_0013;  // ADDI x0,x0,0
  localparam logic [XLEN-1:0] RESET_ADDR = {RESET_PC[XLEN-1:2], 2'b00};

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [XLEN-1:0] fetch_pc_reg, fetch_pc_next;
  logic [XLEN-1:0] resp_pc_reg, resp_pc_next;
  logic [CW-1:0]   inflight_reg, inflight_next;
  logic [CW-1:0]   count_reg, count_next;
  logic [CW-1:0]   drop_reg, drop_next;
  logic [PW-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]   rd_ptr_reg, rd_ptr_next;

  logic [XLEN-1:0] buf_pc    [DEPTH];
  logic [31:0]     buf_instr [DEPTH];

  logic            credit;
  logic            grant;
  logic            resp_keep;
  logic            resp_drop;
  logic            pop;
  logic [XLEN-1:0] target_addr;

  // Only the word-address bits of the redirect target are meaningful.
  logic unused_target_lsbs;
  assign unused_target_lsbs = ^BranchTarget[1:0];

  assign target_addr = {BranchTarget[XLEN-1:2], 2'b00};

  // Stale in-flight words still occupy credit: every granted word will come
  // back and needs a slot (or a drop) regardless of whether it is wanted.
  assign credit = (SW'(inflight_reg) + SW'(count_reg)) < SW'(DEPTH);

  assign grant     = imem_req && imem_gnt;
  assign resp_keep = imem_rvalid && (drop_reg == '0);
  assign resp_drop = imem_rvalid && (drop_reg != '0);
  assign pop       = InstrValid && InstrReady;

  // ---------------------------------------------------------------------------
  // Request FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= BOOT;
    end else begin
      state_reg <= state_next;
    end
  end

  // Credit only shrinks through a grant, so an ungranted request in FETCH
  // stays asserted with the same address until granted or redirected.
  always_comb begin
    state_next = state_reg;
    imem_req   = 1'b0;
    unique case (state_reg)
      BOOT: begin
        state_next = FETCH;
      end
      FETCH: begin
        if (credit) begin
          imem_req = 1'b1;
        end else begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (credit) begin
          state_next = FETCH;
        end
      end
      default: begin
        state_next = BOOT;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pointer / counter next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    inflight_next = inflight_reg + CW'(grant) - CW'(imem_rvalid);
    count_next    = count_reg;
    drop_next     = drop_reg;
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    fetch_pc_next = fetch_pc_reg;
    resp_pc_next  = resp_pc_reg;

    if (BranchTaken) begin
      // Everything still outstanding after this cycle's grant/response is
      // from the wrong path, including a word granted in this very cycle.
      count_next    = '0;
      wr_ptr_next   = '0;
      rd_ptr_next   = '0;
      drop_next     = inflight_next;
      fetch_pc_next = target_addr;
      // The first kept response after a redirect is the first word fetched
      // at the target, so the response PC tracker restarts there.
      resp_pc_next  = target_addr;
    end else begin
      count_next  = count_reg + CW'(resp_keep) - CW'(pop);
      drop_next   = drop_reg - CW'(resp_drop);
      wr_ptr_next = wr_ptr_reg + PW'(resp_keep);
      rd_ptr_next = rd_ptr_reg + PW'(pop);
      if (grant) begin
        fetch_pc_next = fetch_pc_reg + XLEN'(4);
      end
      if (resp_keep) begin
        resp_pc_next = resp_pc_reg + XLEN'(4);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_reg <= RESET_ADDR;
      resp_pc_reg  <= RESET_ADDR;
      inflight_reg <= '0;
      count_reg    <= '0;
      drop_reg     <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
    end else begin
      fetch_pc_reg <= fetch_pc_next;
      resp_pc_reg  <= resp_pc_next;
      inflight_reg <= inflight_next;
      count_reg    <= count_next;
      drop_reg     <= drop_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Instruction buffer storage. Data needs no reset: entries are only visible
  // while the occupancy count says they hold a live word.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (resp_keep) begin
      buf_pc[wr_ptr_reg]    <= resp_pc_reg;
      buf_instr[wr_ptr_reg] <= imem_rdata[31:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign imem_addr  = fetch_pc_reg;
  assign InstrValid = (count_reg != '0);

  // With nothing to offer, decode sees a NOP; PC then shows the address the
  // next kept word will carry (RESET_PC straight out of reset).
  assign Instr   = InstrValid ? buf_instr[rd_ptr_reg] : NOP_INSTR;
  assign PC      = InstrValid ? buf_pc[rd_ptr_reg]    : resp_pc_reg;
  assign PCPlus4 = PC + XLEN'(4);

  assign OP     = Instr[6:0];
  assign Funct3 = Instr[14:12];
  assign Funct7 = Instr[31:25];

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the instruction decoder/control unit in the RV32I subset core (ADD, SUB, AND, OR, SLT, ADDI, LB, SB, BEQ).
- Owns the PC and issues word requests to instruction memory over a request/grant plus in-order response interface.
- Buffers returned words in a small FIFO and presents one instruction per cycle to decode with a valid/ready handshake, already split into OP/Funct3/Funct7.
- Flushes and redirects on a taken BEQ.

Parameters:
- XLEN, 32, address/data width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 2, instruction buffer entries; also the in-flight request cap (power of 2, at least 2).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req  output  1  fetch request valid.
- imem_addr  output  XLEN  fetch byte address; [1:0] always 00.
- imem_gnt  input  1  memory accepts the request this cycle.
- imem_rvalid  input  1  response word valid.
- imem_rdata  input  XLEN  response instruction word.
- BranchTaken  input  1  redirect strobe from execute (Branch and Zero).
- BranchTarget  input  XLEN  redirect address; [1:0] ignored.
- InstrValid  output  1  Instr/PC valid to decode.
- InstrReady  input  1  decode consumes the head instruction.
- Instr  output  32  head instruction.
- PC  output  XLEN  address of Instr.
- PCPlus4  output  XLEN  PC+4, modulo 2^XLEN.
- OP  output  7  Instr[6:0].
- Funct3  output  3  Instr[14:12].
- Funct7  output  7  Instr[31:25].

Behaviour:
- Reset (async, any time including mid-transfer):
  - imem_req=0, imem_addr=RESET_PC, InstrValid=0, Instr=32'h0000_0013 (NOP), PC=RESET_PC.
  - Buffer, in-flight count and drop count all cleared.
- Responses that arrive after reset for pre-reset requests are the memory's concern; the memory is reset by the same rst_n.
- FSM states and transitions:
  - BOOT: the first cycle after rst_n deasserts; no request. Goes to FETCH.
  - FETCH: imem_req=1 while credit exists, i.e. inflight+occupancy < DEPTH. If there is no credit, go to HOLD.
  - HOLD: imem_req=0. Return to FETCH on the cycle after credit frees.
- Request rules:
  - A transfer occurs on imem_req&&imem_gnt.
  - imem_req and imem_addr stay stable until granted, except on redirect.
  - On each grant, fetch PC advances by 4, wrapping mod 2^XLEN.
  - inflight increments on a grant and decrements on imem_rvalid.
- Response rules:
  - Responses are in order with no backpressure; credit guarantees buffer space.
  - If drop>0, the response is discarded and drop decrements.
  - Otherwise the word and its PC are pushed to the buffer.
- Decode side:
  - InstrValid = buffer not empty; Instr/PC come from the buffer head.
  - A word is visible the cycle after its imem_rvalid (registered, no bypass). Minimum grant-to-InstrValid latency is 2 cycles.
  - Pop on InstrValid&&InstrReady.
  - When InstrValid=0, Instr=NOP so decode decodes ADDI x0,x0,0.
  - Push and pop in the same cycle keep occupancy unchanged.
- Redirect (BranchTaken=1, cycle T):
  - Any pop at T completes, since the consumed word is the branch itself.
  - The buffer is flushed at the end of T; InstrValid=0 at T+1.
  - drop := inflight after T's grant/response updates, so every in-flight word, including one granted at T, is stale.
  - Fetch PC := {BranchTarget[XLEN-1:2],2'b00}.
  - A request ungranted at T is abandoned; at T+1 the request carries the target address.
  - Back-to-back redirects reload drop the same way and the last target wins.
  - A redirect during BOOT takes effect; the first request uses the target.
- Credit counts stale in-flight words too, so the buffer can never overflow.

Test Plan:
- Reset then imem_gnt=1 always and 1-cycle response latency, InstrReady=1: addr sequence 0,4,8,...; InstrValid first at cycle 3 after reset release, PC=0, PCPlus4=4.
- Word 0x40208033 returned at PC 0x10: OP=0x33, Funct3=0, Funct7=0x20, PC=0x10, PCPlus4=0x14.
- InstrReady=0 for 6 cycles: exactly DEPTH words buffered, imem_req drops to 0; on release, words pop in order with no loss or duplicate.
- Two requests in flight, BranchTaken=1 with BranchTarget=0x103: both stale responses dropped; next imem_addr=0x100; the first InstrValid word has PC=0x100.
- imem_gnt held 0 for 4 cycles: imem_addr stays constant and PC advances only on grant. Fetch at 0xFFFF_FFFC wraps the next addr to 0.
- Assert rst_n=0 mid-stream with buffer full: outputs return to reset values immediately (async); the first post-reset request is to RESET_PC.
